// File: rtl/key_conditioner_if.sv
// Pushbutton conditioner signal bundle: raw keys and clear mask in,
// debounced levels, edge pulses and sticky press flags out.
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] clr_pending;
  logic [N_KEYS-1:0] key_db_n;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] press_pending;

  modport master (
    output key_n,
    output clr_pending,
    input  key_db_n,
    input  press_pulse,
    input  release_pulse,
    input  press_pending
  );

  modport slave (
    input  key_n,
    input  clr_pending,
    output key_db_n,
    output press_pulse,
    output release_pulse,
    output press_pending
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, stable-level debouncer and press/release edge logic
// for active-low pushbuttons; every output comes straight from a register.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic              CLOCK_50,
  input logic              reset,
  key_conditioner_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] accepted;
  logic [N_KEYS-1:0] accepted_d;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] pending_q;
  logic [CW-1:0]     count [N_KEYS];

  // A level is accepted only after sync2 has disagreed with it for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      accepted <= '1;
      for (int i = 0; i < N_KEYS; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == accepted[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_MAX) begin
          accepted[i] <= sync2[i];
          count[i]    <= '0;
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  // Edge detection against a delayed copy of the accepted level; a press
  // landing on the same edge as a clear wins, so no press is ever lost.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      accepted_d <= '1;
      press_q    <= '0;
      release_q  <= '0;
      pending_q  <= '0;
    end else begin
      accepted_d <= accepted;
      press_q    <= accepted_d & ~accepted;
      release_q  <= ~accepted_d & accepted;
      pending_q  <= (pending_q & ~bus.clr_pending) | (accepted_d & ~accepted);
    end
  end

  assign bus.key_db_n      = accepted;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.press_pending = pending_q;

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter N_KEYS, default 3, the number of pushbutton inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), the consecutive stable cycles required to accept a level change; legal range 2..2^24.
REQ-003 SHALL have port CLOCK_50  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_n  input  N_KEYS  raw active-low pushbuttons, asynchronous to CLOCK_50.
REQ-006 SHALL have port key_db_n  output  N_KEYS  debounced active-low levels, the drop-in feed for the processor keys PIO.
REQ-007 SHALL have port press_pulse  output  N_KEYS  one-cycle high per accepted press (1->0 on key_db_n).
REQ-008 SHALL have port release_pulse  output  N_KEYS  one-cycle high per accepted release (0->1 on key_db_n).
REQ-009 SHALL have port press_pending  output  N_KEYS  sticky per-key press flag.
REQ-010 SHALL have port clr_pending  input  N_KEYS  per-key clear mask for press_pending, sampled every cycle.

Function
REQ-011 SHALL pass each key_n bit through a two-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-012 SHALL keep, per key, an independent counter of width clog2(DEBOUNCE_CYCLES) and an accepted-state bit driving key_db_n.
REQ-013 SHALL, on each edge where sync2 equals the accepted state, clear that key's counter to 0.
REQ-014 SHALL, on each edge where sync2 differs from the accepted state and counter < DEBOUNCE_CYCLES-1, increment the counter by 1.
REQ-015 SHALL, on the edge where sync2 differs and counter = DEBOUNCE_CYCLES-1, load the accepted state from sync2 and clear the counter; the counter never wraps.
REQ-016 SHALL therefore update key_db_n on edge DEBOUNCE_CYCLES+1 after the edge that first samples a stable new key_n level (edge 0), with no earlier change.
REQ-017 SHALL restart the count from 0 on any single-cycle return of sync2 to the accepted state (bounce); a shorter disturbance never reaches key_db_n.
REQ-018 SHALL assert press_pulse[i] during the single cycle following the edge on which key_db_n[i] goes 1->0, and release_pulse[i] likewise for 0->1; never both in one cycle.
REQ-019 SHALL set press_pending[i] on the same edge that asserts press_pulse[i].
REQ-020 SHALL clear press_pending[i] on an edge where clr_pending[i]=1 and no press is accepted on that edge.
REQ-021 SHALL give set priority when a press is accepted and clr_pending[i]=1 on the same edge: press_pending[i] ends 1.
REQ-022 SHALL process all keys fully independently; simultaneous activity on several keys produces simultaneous per-key pulses.
REQ-023 SHALL drive all outputs directly from registers (no combinational path from key_n or clr_pending to any output).

Reset
REQ-024 SHALL, while reset=1, asynchronously force sync1, sync2 and accepted state to 1 (released), all counters to 0, press_pulse, release_pulse and press_pending to 0.
REQ-025 SHALL, on reset asserted mid-count or mid-pulse, abort the count and emit no pulse for it; after release a key already held low is accepted as a normal press DEBOUNCE_CYCLES+1 edges after first sampling.
REQ-026 SHALL begin normal operation on the first rising edge after reset deasserts; reset deassertion is synchronized externally.

Verification (DEBOUNCE_CYCLES=4, N_KEYS=3)
REQ-027 SHALL check reset: reset=1 with key_n=3'b000 -> key_db_n=3'b111, press_pulse=release_pulse=press_pending=3'b000, held throughout reset.
REQ-028 SHALL check clean press: key_n[0] 1->0 stable before edge 0 -> key_db_n[0]=0 after edge 5, press_pulse[0]=1 for exactly the cycle after edge 6, press_pending[0]=1 from edge 6.
REQ-029 SHALL check bounce: key_n[1] low 3 cycles, high 1 cycle, low 2 cycles, then high -> key_db_n[1] stays 1, no pulses; then low 6 cycles -> press accepted.
REQ-030 SHALL check release and clear: after press accepted, clr_pending=3'b001 one cycle -> press_pending[0]=0; key_n[0] back to 1 -> release_pulse[0] one cycle, press_pending unaffected.
REQ-031 SHALL check set-over-clear: clr_pending[2]=1 held across the edge press_pending[2] is set -> press_pending[2]=1 afterwards.
REQ-032 SHALL check reset mid-count: key_n[0]=0, reset pulsed when counter=2 -> no pulse, key_db_n[0]=1; key held low -> press accepted edge 5 after reset release.
